mdu_e: RTL

- E-stage multiply/divide unit, sitting beside the ALU.
- Consumes the same forwarded A/B operands as the ALU.
- Its HI/LO read result (mfhi/mflo) travels down the E→M path alongside ALU output C.
- Multi-cycle unit with internal HI/LO registers and a busy counter; the hazard unit uses the busy indication to stall D.

---
 rtl/mdu_e.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mdu_e.sv
// mdu_e: E-stage multiply/divide unit with HI/LO registers.
// An accepted mult/div latches its operands and runs a down-counter for a
// fixed number of cycles. The result is written into HI/LO on the edge where
// the counter reaches zero, and busy drops on that same edge.
module mdu_e #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDU_op,
   input  logic        start,
   input  logic        req,
   input  logic        rd_hi,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] MD_out,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
   localparam logic [CW-1:0] CNT_MULT_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] CNT_DIV_N  = CW'(DIV_CYCLES);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [2:0]    op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;

   logic          is_md_op_s;
   logic          accept_s;
   logic          is_mul_s;
   logic          is_signed_s;
   logic [63:0]   a_ext_s, b_ext_s, prod_s;
   logic          a_neg_s, b_neg_s;
   logic [31:0]   a_mag_s, b_mag_s;
   logic [31:0]   uquot_s, urem_s;
   logic [31:0]   quot_s, rem_s;

   // Start decode: a request to begin mult/multu/div/divu this cycle.
   always_comb begin
      is_md_op_s = (MDU_op >= OP_MULT) && (MDU_op <= OP_DIVU);
      accept_s   = start & ~req & ~busy_q & is_md_op_s;
      stall_req  = busy_q | (start & ~req & is_md_op_s);
   end

   // Arithmetic on the latched operands; only sampled on the completion edge.
   always_comb begin
      is_mul_s    = (op_q == OP_MULT) || (op_q == OP_MULTU);
      is_signed_s = (op_q == OP_MULT) || (op_q == OP_DIV);
      // Sign- or zero-extension to 64 bits makes the low 64 bits of a plain
      // multiply correct for both signed and unsigned products.
      a_ext_s = is_signed_s ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
      b_ext_s = is_signed_s ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
      prod_s  = a_ext_s * b_ext_s;
      // Signed division via magnitudes: quotient truncates toward zero and
      // the remainder takes the sign of the dividend. 0x80000000 / -1 gives
      // a magnitude of 0x80000000 whose negation wraps back to 0x80000000.
      a_neg_s = is_signed_s & a_q[31];
      b_neg_s = is_signed_s & b_q[31];
      a_mag_s = a_neg_s ? (32'd0 - a_q) : a_q;
      b_mag_s = b_neg_s ? (32'd0 - b_q) : b_q;
      if (b_mag_s != 32'd0) begin
         uquot_s = a_mag_s / b_mag_s;
         urem_s  = a_mag_s % b_mag_s;
      end else begin
         uquot_s = 32'd0;
         urem_s  = 32'd0;
      end
      quot_s = (a_neg_s ^ b_neg_s) ? (32'd0 - uquot_s) : uquot_s;
      rem_s  = a_neg_s ? (32'd0 - urem_s) : urem_s;
   end

   // Next-state: countdown and completion write, else accept, else mthi/mtlo.
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      a_d    = a_q;
      b_d    = b_q;
      op_d   = op_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (busy_q) begin
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            busy_d = 1'b0;
            if (is_mul_s) begin
               hi_d = prod_s[63:32];
               lo_d = prod_s[31:0];
            end else if (b_q != 32'd0) begin
               hi_d = rem_s;
               lo_d = quot_s;
            end else begin
               // Divide by zero leaves HI/LO untouched.
               hi_d = hi_q;
               lo_d = lo_q;
            end
         end else begin
            busy_d = 1'b1;
         end
      end else if (accept_s) begin
         a_d    = A;
         b_d    = B;
         op_d   = MDU_op;
         busy_d = 1'b1;
         cnt_d  = ((MDU_op == OP_MULT) || (MDU_op == OP_MULTU)) ? CNT_MULT_N : CNT_DIV_N;
      end else if (~req && (MDU_op == OP_MTHI)) begin
         hi_d = A;
      end else if (~req && (MDU_op == OP_MTLO)) begin
         lo_d = A;
      end else begin
         busy_d = 1'b0;
      end
   end

   // State registers; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         a_q    <= 32'd0;
         b_q    <= 32'd0;
         op_q   <= 3'd0;
         cnt_q  <= CNT_ZERO;
         busy_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         a_q    <= a_d;
         b_q    <= b_d;
         op_q   <= op_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   // Output mapping; the HI/LO read port is combinational from the registers.
   always_comb begin
      busy   = busy_q;
      HI     = hi_q;
      LO     = lo_q;
      MD_out = rd_hi ? hi_q : lo_q;
   end

endmodule
